ping_pong_seven_seg_driver: RTL and testbench
=============================================

// Module: ping_pong_seven_seg_driver
// PURPOSE
//   Downstream display stage for the parameterized ping-pong counter: takes its 4-bit
//   count and direction flag and drives a 4-digit, common-anode, time-multiplexed
//   7-segment display. Digits 1:0 show the count in decimal (00..15); digits 3:2 show
//   a direction glyph. Inputs are snapshotted once per scan frame so no frame tears.
// PARAMETERS
//   SCAN_PERIOD  100000  clk cycles each digit is lit (>=2); frame = 4*SCAN_PERIOD
//   CNT_W        $clog2(SCAN_PERIOD)  scan prescaler width (derived, do not override)
// PORTS
//   clk        in   1  system clock; all state on rising edge
//   rst        in   1  synchronous, active-high reset
//   value      in   4  counter output to display (0..15)
//   direction  in   1  1 = counting up, 0 = counting down
//   blank      in   1  1 = all digits off; scanning continues
//   an         out  4  digit anodes, active-low; an[0] = rightmost digit
//   seg        out  7  segments {g,f,e,d,c,b,a}, active-low
//   dp         out  1  decimal point, active-low; constant 1 (off)
// BEHAVIOUR
//   Reset (rst=1 at posedge): cnt=0, idx=0, shadow_val=0, shadow_dir=1,
//     an=4'b1111, seg=7'b1111111, dp=1. Reset wins over every other event.
//   Prescaler: cnt counts 0..SCAN_PERIOD-1; at SCAN_PERIOD-1 cnt->0 and idx->idx+1
//     (2-bit, 3 wraps to 0). Each digit is selected for exactly SCAN_PERIOD cycles.
//   Snapshot: when cnt==SCAN_PERIOD-1 && idx==3, shadow_val<=value,
//     shadow_dir<=direction. No other cycle loads the shadow; input changes mid-frame
//     are not visible until the next frame starts (latency <= 4*SCAN_PERIOD+1).
//   Outputs are registered, one cycle behind idx/shadow:
//     blank=1 -> an=4'b1111, seg=7'b1111111.
//     else an=~(4'b0001<<idx); seg by idx:
//       0: ones digit = shadow_val mod 10     1: tens digit = (shadow_val>=10)?1:0
//       2,3: shadow_dir ? UP : DOWN
//   Glyphs (active-low {g..a}): 0=1000000 1=1111001 2=0100100 3=0110000 4=0011001
//     5=0010010 6=0000010 7=1111000 8=0000000 9=0010000 UP=0011100 (a,b,f,g)
//     DOWN=0100011 (c,d,e,g) BLANK=1111111. Tens shows a leading '0' (no suppression).
//   blank toggling does not stop or reset cnt/idx or the snapshot.
//   Decimal split: ones = value>=10 ? value-10 : value (no divider).
// STRUCTURE
//   seven_seg_pkg (shared): glyph constants above, digit-index constants.
//   Sub-module seven_seg_decoder: combinational 4-bit digit -> 7-bit glyph (0..9,
//     others -> BLANK), reused by later display blocks.
//   Top: prescaler, idx counter, shadow regs, digit mux, output regs.
// TESTING (bench uses SCAN_PERIOD=4)
//   1 rst=1 two cycles -> an=1111, seg=1111111, dp=1; first cycle after release
//     an=1110, seg=1000000; an stays 1110 exactly 4 cycles, then 1101.
//   2 value=4, dir=1 applied at idx=1 -> current frame still shows 00/UP; next frame
//     an0 seg=0011001, an1 seg=1000000, an2/an3 seg=0011100.
//   3 value=12, dir=0 -> next frame ones seg=0100100, tens seg=1111001,
//     digits 2/3 seg=0100011.
//   4 blank=1 during idx=2 -> an=1111 next cycle, idx keeps advancing; blank=0 at
//     idx=0 -> an=1110 next cycle with correct ones glyph.
//   5 value changed every cycle across a frame -> all 4 digits of each frame decode
//     the value present at the cycle cnt==3 && idx==3 before it (no tearing).
//   6 rst=1 asserted while idx=2, cnt=1 -> next cycle all outputs at reset values,
//     shadow 0/UP; scan restarts at idx=0 with a full 4-cycle dwell.

Source files
------------

// File: rtl/seven_seg_pkg.sv
// Shared 7-segment constants: active-low glyphs {g,f,e,d,c,b,a}, digit slots,
// and the subtract-ten decimal split used by the display drivers.
package seven_seg_pkg;

    localparam logic [6:0] GLYPH_0     = 7'b1000000;
    localparam logic [6:0] GLYPH_1     = 7'b1111001;
    localparam logic [6:0] GLYPH_2     = 7'b0100100;
    localparam logic [6:0] GLYPH_3     = 7'b0110000;
    localparam logic [6:0] GLYPH_4     = 7'b0011001;
    localparam logic [6:0] GLYPH_5     = 7'b0010010;
    localparam logic [6:0] GLYPH_6     = 7'b0000010;
    localparam logic [6:0] GLYPH_7     = 7'b1111000;
    localparam logic [6:0] GLYPH_8     = 7'b0000000;
    localparam logic [6:0] GLYPH_9     = 7'b0010000;
    localparam logic [6:0] GLYPH_UP    = 7'b0011100;
    localparam logic [6:0] GLYPH_DOWN  = 7'b0100011;
    localparam logic [6:0] GLYPH_BLANK = 7'b1111111;

    localparam logic [1:0] DIG_ONES   = 2'd0;
    localparam logic [1:0] DIG_TENS   = 2'd1;
    localparam logic [1:0] DIG_DIR_LO = 2'd2;
    localparam logic [1:0] DIG_DIR_HI = 2'd3;

    localparam logic [3:0] AN_OFF      = 4'b1111;
    localparam logic [3:0] DIGIT_BLANK = 4'd15;

    // Values 0..15 only need a single conditional subtract, no divider.
    function automatic logic [3:0] ones_digit(input logic [3:0] v);
        if (v >= 4'd10) begin
            return v - 4'd10;
        end else begin
            return v;
        end
    endfunction

    function automatic logic [3:0] tens_digit(input logic [3:0] v);
        if (v >= 4'd10) begin
            return 4'd1;
        end else begin
            return 4'd0;
        end
    endfunction

endpackage

// File: rtl/seven_seg_decoder.sv
// Combinational BCD digit to active-low 7-segment glyph; non-decimal codes go dark.
module seven_seg_decoder
    import seven_seg_pkg::*;
(
    input  logic [3:0] digit_i,
    output logic [6:0] seg_o
);

    // Glyph lookup
    always_comb begin
        seg_o = GLYPH_BLANK;
        case (digit_i)
            4'd0:    seg_o = GLYPH_0;
            4'd1:    seg_o = GLYPH_1;
            4'd2:    seg_o = GLYPH_2;
            4'd3:    seg_o = GLYPH_3;
            4'd4:    seg_o = GLYPH_4;
            4'd5:    seg_o = GLYPH_5;
            4'd6:    seg_o = GLYPH_6;
            4'd7:    seg_o = GLYPH_7;
            4'd8:    seg_o = GLYPH_8;
            4'd9:    seg_o = GLYPH_9;
            default: seg_o = GLYPH_BLANK;
        endcase
    end

endmodule

// File: rtl/ping_pong_seven_seg_driver.sv
// 4-digit multiplexed common-anode display of a ping-pong count (digits 1:0) and
// its direction glyph (digits 3:2); inputs are latched once per scan frame.
module ping_pong_seven_seg_driver
    import seven_seg_pkg::*;
#(
    parameter int SCAN_PERIOD = 100000,
    parameter int CNT_W       = (SCAN_PERIOD > 1) ? $clog2(SCAN_PERIOD) : 1
) (
    input  logic       clk,
    input  logic       rst,
    input  logic [3:0] value,
    input  logic       direction,
    input  logic       blank,
    output logic [3:0] an,
    output logic [6:0] seg,
    output logic       dp
);

    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(SCAN_PERIOD - 1);

    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic [1:0]       idx_q, idx_d;
    logic [3:0]       shadow_val_q, shadow_val_d;
    logic             shadow_dir_q, shadow_dir_d;
    logic [3:0]       an_q, an_d;
    logic [6:0]       seg_q, seg_d;
    logic             dp_q;
    logic             wrap_s;
    logic             snap_s;
    logic [3:0]       digit_s;
    logic [6:0]       dec_seg_s;

    assign wrap_s = (cnt_q == CNT_LAST);
    // Loading only on the last cycle of digit 3 keeps all four digits of a frame coherent.
    assign snap_s = wrap_s && (idx_q == DIG_DIR_HI);

    // Prescaler, scan index and frame snapshot next-state
    always_comb begin
        cnt_d        = cnt_q + CNT_W'(1);
        idx_d        = idx_q;
        shadow_val_d = shadow_val_q;
        shadow_dir_d = shadow_dir_q;
        if (wrap_s) begin
            cnt_d = {CNT_W{1'b0}};
            idx_d = idx_q + 2'd1;
        end else begin
            cnt_d = cnt_q + CNT_W'(1);
        end
        if (snap_s) begin
            shadow_val_d = value;
            shadow_dir_d = direction;
        end else begin
            shadow_val_d = shadow_val_q;
            shadow_dir_d = shadow_dir_q;
        end
    end

    // Numeric digit selected for the current scan slot
    always_comb begin
        digit_s = DIGIT_BLANK;
        case (idx_q)
            DIG_ONES: digit_s = ones_digit(shadow_val_q);
            DIG_TENS: digit_s = tens_digit(shadow_val_q);
            default:  digit_s = DIGIT_BLANK;
        endcase
    end

    seven_seg_decoder u_decoder (
        .digit_i (digit_s),
        .seg_o   (dec_seg_s)
    );

    // Anode and segment next-state
    always_comb begin
        an_d  = AN_OFF;
        seg_d = GLYPH_BLANK;
        if (blank) begin
            an_d  = AN_OFF;
            seg_d = GLYPH_BLANK;
        end else begin
            an_d = ~(4'b0001 << idx_q);
            case (idx_q)
                DIG_DIR_LO, DIG_DIR_HI: seg_d = shadow_dir_q ? GLYPH_UP : GLYPH_DOWN;
                default:                seg_d = dec_seg_s;
            endcase
        end
    end

    // State and output registers
    always_ff @(posedge clk) begin
        if (rst) begin
            cnt_q        <= {CNT_W{1'b0}};
            idx_q        <= 2'd0;
            shadow_val_q <= 4'd0;
            shadow_dir_q <= 1'b1;
            an_q         <= AN_OFF;
            seg_q        <= GLYPH_BLANK;
            dp_q         <= 1'b1;
        end else begin
            cnt_q        <= cnt_d;
            idx_q        <= idx_d;
            shadow_val_q <= shadow_val_d;
            shadow_dir_q <= shadow_dir_d;
            an_q         <= an_d;
            seg_q        <= seg_d;
            dp_q         <= 1'b1;
        end
    end

    assign an  = an_q;
    assign seg = seg_q;
    assign dp  = dp_q;

endmodule

// File: tb/tb_ping_pong_seven_seg_driver.sv
// Frame-level bench for the seven-segment driver with a 4-cycle dwell per digit.
module tb_ping_pong_seven_seg_driver;

    localparam logic [6:0] G0   = 7'b1000000;
    localparam logic [6:0] G1   = 7'b1111001;
    localparam logic [6:0] UP   = 7'b0011100;
    localparam logic [6:0] DOWN = 7'b0100011;

    typedef struct {
        logic [3:0] value;
        logic       dir;
        logic [6:0] ones;
        logic [6:0] tens;
        logic [6:0] dirg;
    } vec_t;

    typedef struct {
        logic [3:0] an;
        logic [6:0] seg;
    } exp_t;

    logic       clk = 1'b0;
    logic       rst;
    logic [3:0] value;
    logic       direction;
    logic       blank;
    logic [3:0] an;
    logic [6:0] seg;
    logic       dp;

    exp_t       sb[$];
    vec_t       tab[7];
    logic [6:0] glyph[10];
    int         n_cmp = 0;
    int         n_bad = 0;
    int         frame_no = 0;

    always #5 clk = ~clk;

    ping_pong_seven_seg_driver #(.SCAN_PERIOD(4)) dut (
        .clk       (clk),
        .rst       (rst),
        .value     (value),
        .direction (direction),
        .blank     (blank),
        .an        (an),
        .seg       (seg),
        .dp        (dp)
    );

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic check(input string name, input logic [11:0] act, input logic [11:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got an=%b seg=%b dp=%b, want an=%b seg=%b dp=%b",
                     name, act[11:8], act[7:1], act[0], exp[11:8], exp[7:1], exp[0]);
        end
    endtask

    task automatic push_frame(input logic [6:0] o, input logic [6:0] t, input logic [6:0] dg);
        sb.push_back('{4'b1110, o});
        sb.push_back('{4'b1101, t});
        sb.push_back('{4'b1011, dg});
        sb.push_back('{4'b0111, dg});
    endtask

    task automatic push_value(input logic [3:0] v, input logic d);
        int ov;
        ov = (v >= 4'd10) ? int'(v) - 10 : int'(v);
        push_frame(glyph[ov], (v >= 4'd10) ? G1 : G0, d ? UP : DOWN);
    endtask

    // One 16-cycle frame: compare every cycle against the queue head, pop at end of each dwell.
    task automatic do_frame(input bit push_next, input vec_t nv, input bit rnd,
                            input bit blnk, input bit rst_mid);
        exp_t e;
        for (int k = 0; k < 16; k++) begin
            tick();
            if (sb.size() == 0) begin
                n_cmp++;
                n_bad++;
                $display("FAIL sb_empty frame%0d k%0d: got an=%b seg=%b, want queued entry",
                         frame_no, k, an, seg);
            end else begin
                e = sb[0];
                if (blnk && k >= 9)
                    check($sformatf("blank f%0d k%0d", frame_no, k), {an, seg, dp},
                          {4'b1111, 7'b1111111, 1'b1});
                else
                    check($sformatf("digit f%0d k%0d", frame_no, k), {an, seg, dp},
                          {e.an, e.seg, 1'b1});
                if (k % 4 == 3) void'(sb.pop_front());
            end
            if (push_next && !rnd && k == 4) begin
                value     = nv.value;
                direction = nv.dir;
                push_frame(nv.ones, nv.tens, nv.dirg);
            end
            if (rnd) begin
                value     = 4'($urandom_range(0, 15));
                direction = 1'($urandom_range(0, 1));
                if (k == 14) push_value(value, direction);
            end
            if (blnk && k == 8)  blank = 1'b1;
            if (blnk && k == 15) blank = 1'b0;
            if (rst_mid && k == 8) begin
                rst = 1'b1;
                tick();
                check("mid_reset", {an, seg, dp}, {4'b1111, 7'b1111111, 1'b1});
                rst = 1'b0;
                sb.delete();
                frame_no++;
                return;
            end
        end
        frame_no++;
    endtask

    initial begin
        vec_t v9;
        glyph[0] = 7'b1000000; glyph[1] = 7'b1111001; glyph[2] = 7'b0100100;
        glyph[3] = 7'b0110000; glyph[4] = 7'b0011001; glyph[5] = 7'b0010010;
        glyph[6] = 7'b0000010; glyph[7] = 7'b1111000; glyph[8] = 7'b0000000;
        glyph[9] = 7'b0010000;

        tab[0] = '{4'd4,  1'b1, 7'b0011001, G0, UP};
        tab[1] = '{4'd12, 1'b0, 7'b0100100, G1, DOWN};
        tab[2] = '{4'd9,  1'b1, 7'b0010000, G0, UP};
        tab[3] = '{4'd15, 1'b0, 7'b0010010, G1, DOWN};
        tab[4] = '{4'd10, 1'b1, 7'b1000000, G1, UP};
        tab[5] = '{4'd0,  1'b0, 7'b1000000, G0, DOWN};
        tab[6] = '{4'd7,  1'b1, 7'b1111000, G0, UP};
        v9     = '{4'd9,  1'b0, 7'b0010000, G0, DOWN};

        rst       = 1'b1;
        value     = 4'd0;
        direction = 1'b1;
        blank     = 1'b0;
        tick();
        check("reset_c1", {an, seg, dp}, {4'b1111, 7'b1111111, 1'b1});
        tick();
        check("reset_c2", {an, seg, dp}, {4'b1111, 7'b1111111, 1'b1});
        rst = 1'b0;

        push_frame(G0, G0, UP);
        for (int i = 0; i < 7; i++) do_frame(1'b1, tab[i], 1'b0, 1'b0, 1'b0);

        do_frame(1'b1, '{4'd5, 1'b1, 7'b0010010, G0, UP}, 1'b0, 1'b1, 1'b0);
        do_frame(1'b1, tab[0], 1'b1, 1'b0, 1'b0);
        do_frame(1'b1, tab[0], 1'b1, 1'b0, 1'b0);
        do_frame(1'b1, tab[1], 1'b0, 1'b0, 1'b0);

        do_frame(1'b0, tab[0], 1'b0, 1'b0, 1'b1);
        value     = 4'd9;
        direction = 1'b0;
        push_frame(G0, G0, UP);
        do_frame(1'b1, v9, 1'b0, 1'b0, 1'b0);
        do_frame(1'b0, v9, 1'b0, 1'b0, 1'b0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
